// File: rtl/cb_dina_map.sv
// Cache-bank write mapper: routes RSA/host/zero rows onto bank lanes (positive, reversed, or NEW pair).
// Optional sticky select-error flag enabled by defining CB_DINA_ERR_EN.

module cb_dina_lane #(
   parameter int X      = 4,
   parameter int RSA_DW = 16,
   parameter int LANE   = 0
) (
   input  logic [1:0]          dir,
   input  logic [1:0]          pair_sel,
   input  logic [X*RSA_DW-1:0] row,
   output logic                wea,
   output logic [RSA_DW-1:0]   data
);
   localparam logic [1:0] IDX = 2'(LANE);

   logic [1:0] a, b;

   // NEW mode: landmark bits pick which bank pair receives source lanes 0 and 1
   always_comb begin
      case (pair_sel)
         2'b11:   begin a = 2'd0; b = 2'd1; end
         2'b00:   begin a = 2'd2; b = 2'd3; end
         2'b01:   begin a = 2'd3; b = 2'd2; end
         default: begin a = 2'd1; b = 2'd0; end
      endcase
   end

   always_comb begin
      wea  = 1'b0;
      data = '0;
      case (dir)
         2'b01: begin
            wea  = 1'b1;
            data = row[LANE*RSA_DW +: RSA_DW];
         end
         2'b10: begin
            wea  = 1'b1;
            data = row[(X-1-LANE)*RSA_DW +: RSA_DW];
         end
         2'b11: begin
            if (a == IDX) begin
               wea  = 1'b1;
               data = row[0 +: RSA_DW];
            end else if (b == IDX) begin
               wea  = 1'b1;
               data = row[RSA_DW +: RSA_DW];
            end
         end
         default: ;
      endcase
   end
endmodule

module cb_dina_map #(
   parameter int X       = 4,
   parameter int L       = 4,
   parameter int RSA_DW  = 16,
   parameter int ROW_LEN = 10
) (
   input  logic                  clk,
   input  logic                  sys_rst_n,
   input  logic                  start,
   input  logic [3:0]            CB_dina_sel,
   input  logic [ROW_LEN-1:0]    landmark_num,
   input  logic [ROW_LEN-1:0]    burst_len,
   input  logic [ROW_LEN-1:0]    base_addr,
   input  logic [X*RSA_DW-1:0]   C_dout,
   input  logic [X*RSA_DW-1:0]   H_din,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  CB_ready,
   output logic                  CB_ena,
   output logic [L-1:0]          CB_wea,
   output logic [ROW_LEN-1:0]    CB_addra,
   output logic [L*RSA_DW-1:0]   CB_dina,
   output logic                  busy,
   output logic                  done,
   output logic                  sel_err
);
   typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;

   localparam logic [ROW_LEN-1:0] ONE = {{(ROW_LEN-1){1'b0}}, 1'b1};

   state_t               state, state_nxt;
   logic [3:0]           sel_q;
   logic [1:0]           lm_q;
   logic [ROW_LEN-1:0]   len_q, base_q, cnt, cnt_inc;
   logic                 done_q;
   logic [1:0]           src, dir, lane_dir;
   logic                 slot_free, self_gen, beat_go, last_beat, start_go, start_zero;
   logic [X*RSA_DW-1:0]  row;
   logic [L-1:0]         wea_nxt;
   logic [L*RSA_DW-1:0]  dina_nxt;
   logic                 unused_lm;

   assign unused_lm  = ^landmark_num[ROW_LEN-1:2];
   assign src        = sel_q[3:2];
   assign dir        = sel_q[1:0];
   assign slot_free  = !CB_ena || CB_ready;
   // Idle and zero-fill sources have no upstream: they generate beats on their own
   assign self_gen   = (src == 2'b00) || (src == 2'b11);
   assign start_go   = (state == IDLE) && start && (burst_len != '0);
   assign start_zero = (state == IDLE) && start && (burst_len == '0);
   assign beat_go    = (state == BURST) && slot_free && (self_gen || in_valid);
   assign cnt_inc    = cnt + ONE;
   assign last_beat  = beat_go && (cnt_inc == len_q);
   assign lane_dir   = (src == 2'b00) ? 2'b00 : dir;
   assign done       = done_q;

   always_comb begin
      case (src)
         2'b01:   row = C_dout;
         2'b10:   row = H_din;
         default: row = '0;
      endcase
   end

   for (genvar i = 0; i < L; i++) begin : g_lane
      cb_dina_lane #(.X(X), .RSA_DW(RSA_DW), .LANE(i)) u_lane (
         .dir      (lane_dir),
         .pair_sel (lm_q),
         .row      (row),
         .wea      (wea_nxt[i]),
         .data     (dina_nxt[i*RSA_DW +: RSA_DW])
      );
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_go)  state_nxt = BURST;
         BURST:   if (last_beat) state_nxt = FLUSH;
         FLUSH:   if (slot_free) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      in_ready = (state == BURST) && ((src == 2'b01) || (src == 2'b10)) && slot_free;
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sel_q    <= '0;
         lm_q     <= '0;
         len_q    <= '0;
         base_q   <= '0;
         cnt      <= '0;
         done_q   <= 1'b0;
         CB_ena   <= 1'b0;
         CB_wea   <= '0;
         CB_addra <= '0;
         CB_dina  <= '0;
      end else begin
         done_q <= start_zero || ((state == FLUSH) && slot_free);
         if (start_go) begin
            sel_q  <= CB_dina_sel;
            lm_q   <= landmark_num[1:0];
            len_q  <= burst_len;
            base_q <= base_addr;
            cnt    <= '0;
         end else if (beat_go) begin
            cnt <= cnt_inc;
         end
         // Single output slot: load a new beat, else drop ena once the bank takes it
         if (beat_go) begin
            CB_ena   <= 1'b1;
            CB_wea   <= wea_nxt;
            CB_addra <= base_q + cnt;
            CB_dina  <= dina_nxt;
         end else if (CB_ready) begin
            CB_ena <= 1'b0;
         end
      end
   end

`ifdef CB_DINA_ERR_EN
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         sel_err <= 1'b0;
      else if ((start_go && ((CB_dina_sel[3:2] == 2'b00) || (CB_dina_sel[1:0] == 2'b00))) ||
               ((state == IDLE) && in_valid))
         sel_err <= 1'b1;
   end
`else
   assign sel_err = 1'b0;
`endif
endmodule

// File: doc/cb_dina_map.md
CB_DINA_MAP -- requirements
Module: cb_dina_map

Interface
REQ-001 Parameters SHALL be, one per line:
- X, 4, systolic-array result lanes.
- L, 4, cache-bank lanes; X==L==4 is the only supported build.
- RSA_DW, 16, lane data width.
- ROW_LEN, 10, address, burst-length and landmark-count width.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle burst start pulse.
- CB_dina_sel  in  4  [3:2] source: 00 idle, 01 RSA result, 10 host data, 11 zero-fill; [1:0] direction: 00 idle, 01 positive, 10 negative, 11 NEW.
- landmark_num  in  ROW_LEN  landmark count; bits [1:0] select the NEW bank pair.
- burst_len  in  ROW_LEN  number of beats in the burst.
- base_addr  in  ROW_LEN  first bank address.
- C_dout  in  X*RSA_DW  RSA result row.
- H_din  in  X*RSA_DW  host row.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&&in_ready.
- CB_ready  in  1  bank accepts the current write.
- CB_ena  out  1  write beat valid.
- CB_wea  out  L  per-lane write enable.
- CB_addra  out  ROW_LEN  write address.
- CB_dina  out  L*RSA_DW  write data.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle completion pulse.
- sel_err  out  1  sticky illegal-select flag.

Function
REQ-003 The FSM SHALL have three states: IDLE, BURST, FLUSH.
REQ-004 In IDLE, start with burst_len!=0 SHALL latch CB_dina_sel, landmark_num[1:0], burst_len and base_addr, clear the beat counter, and enter BURST.
- start with burst_len==0 SHALL pulse done on the next cycle and remain in IDLE.
- start outside IDLE SHALL be ignored.
REQ-005 The output stage SHALL be a single register (CB_ena, CB_wea, CB_addra, CB_dina) that holds its contents while CB_ena&&!CB_ready and clears CB_ena on CB_ready when no new beat is loaded.
REQ-006 For sources 01 and 10, in_ready SHALL be BURST&&(!CB_ena||CB_ready). in_ready SHALL be 0 in every other state and for source 11.
REQ-007 Source 11 SHALL self-generate all-zero beats whenever BURST&&(!CB_ena||CB_ready), ignoring in_valid.
REQ-008 Latency SHALL be 1 cycle: a beat accepted at edge n appears on CB_ena at edge n+1. Full throughput of one beat per cycle SHALL be achieved when CB_ready is held at 1.
REQ-009 Beat k (0-based) SHALL use CB_addra=base_addr+k, truncated modulo 2^ROW_LEN.
REQ-010 Direction 01 SHALL write bank lane i <- source lane i with CB_wea=4'b1111.
REQ-011 Direction 10 SHALL write bank lane i <- source lane X-1-i with CB_wea=4'b1111.
REQ-012 Direction 11 (NEW) SHALL write bank lanes (a,b) <- source lanes (0,1), with CB_wea set only on a and b and zero data on the other lanes. (a,b) SHALL be selected by latched landmark_num[1:0]:
- 11 -> (0,1)
- 00 -> (2,3)
- 01 -> (3,2)
- 10 -> (1,0)
REQ-013 A latched source 00 or direction 00 SHALL produce beats with CB_wea=0 and zero data; beats SHALL still be counted.
REQ-014 When the accepted or generated beat count reaches the latched burst_len, the FSM SHALL enter FLUSH.
REQ-015 FLUSH SHALL exit to IDLE on the cycle CB_ena is 0 or CB_ready is 1, with done asserted for exactly that one cycle.
REQ-016 busy SHALL equal (state!=IDLE).
REQ-017 Changes to CB_dina_sel, landmark_num or base_addr during BURST or FLUSH SHALL have no effect.

Reset
REQ-018 While sys_rst_n=0, the module SHALL asynchronously force IDLE, beat counter 0, and CB_ena, CB_wea, CB_addra, CB_dina, in_ready, busy, done and sel_err to 0.
REQ-019 Reset asserted mid-burst SHALL discard the pending output beat with no done pulse. The first start after release SHALL behave as from power-up.

Configuration
REQ-020 With CB_DINA_ERR_EN defined, sel_err SHALL set on a start that latches source 00 or direction 00. It SHALL also set on in_valid=1 while in IDLE. It SHALL clear only on reset.
REQ-021 Without CB_DINA_ERR_EN, sel_err SHALL be tied to 0 and all other behaviour SHALL be unchanged.

Verification
REQ-022 Positive burst:
- Stimulus: sel=0101, burst_len=3, base_addr=10, CB_ready=1, C_dout lanes {4,3,2,1}.
- Response: three beats, addr 10,11,12; CB_dina equals C_dout; CB_wea=1111; done one cycle after the last CB_ena.
REQ-023 Negative host burst:
- Stimulus: sel=1010, H_din lanes0..3={A,B,C,D}.
- Response: CB_dina lanes0..3={D,C,B,A}.
REQ-024 NEW sweep:
- Stimulus: sel=0111, landmark_num[1:0] stepped through 11, 00, 01, 10, source lanes0,1={5,6}.
- Response: CB_wea 0011, 1100, 1100, 0011; bank pair (0,1), (2,3), (3,2), (1,0) holds {5,6}; remaining lanes 0.
REQ-025 Backpressure:
- Stimulus: CB_ready=0 for 4 cycles mid-burst.
- Response: output held stable; in_ready=0; no beat lost or duplicated; total CB_ena&&CB_ready handshakes equal burst_len.
REQ-026 Zero-fill with reset:
- Stimulus: sel=1101, burst_len=2, base_addr=1023 (ROW_LEN=10).
- Response: addresses 1023 then 0, data 0, CB_wea=1111.
- Then: sys_rst_n=0 asserted mid-burst of a burst_len=4 run -> all outputs 0 immediately, no done.
REQ-027 Error flag:
- With CB_DINA_ERR_EN defined: start with sel=0000 -> sel_err=1 and stays 1.
- Without the macro: same stimulus -> sel_err=0.
